// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multicycle one-bit-per-cycle shift controller with amount-mux select
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       amt_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amt_in,
  output logic [1:0]       ShiftAmt,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] count;

  // Only the low AMT_W bits of the muxed amount matter; the rest are ignored.
  logic amt_unused;
  assign amt_unused = ^amt_in[WIDTH-1:AMT_W];

  // Sequencer: select the amount source, load operand, shift one bit per edge, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_SLL;
      count    <= '0;
      ShiftAmt <= 2'b00;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            ShiftAmt <= amt_sel;
            busy     <= 1'b1;
            state    <= SEL;
          end
        end

        SEL: begin
          // The mux has had a full cycle to settle on ShiftAmt, so amt_in is valid here.
          if (op_q == ILLEGAL || ShiftAmt == ILLEGAL) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            result <= data_in;
            count  <= amt_in[AMT_W-1:0];
            if (amt_in[AMT_W-1:0] == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end

        SHIFT: begin
          case (op_q)
            OP_SLL:  result <= {result[WIDTH-2:0], 1'b0};
            OP_SRL:  result <= {1'b0, result[WIDTH-1:1]};
            OP_SRA:  result <= {result[WIDTH-1], result[WIDTH-1:1]};
            default: result <= result;
          endcase
          count <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  amt_sel;
  logic [31:0] data_in;
  logic [31:0] amt_in;
  logic [1:0]  ShiftAmt;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        err;

  int checks = 0;
  int passes = 0;

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .amt_sel  (amt_sel),
    .data_in  (data_in),
    .amt_in   (amt_in),
    .ShiftAmt (ShiftAmt),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] f_shift(input logic [31:0] d, input logic [1:0] o, input int n);
    case (o)
      2'b00:   return d << n;
      2'b01:   return d >> n;
      default: return 32'($signed(d) >>> n);
    endcase
  endfunction

  // Reference model: a request accepted at edge k is resolved at edge k+1 and
  // finishes at edge k+1+N; the result after edge e is the operand shifted by e-k-1.
  int          e = 0;
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_k, m_done_edge;
  bit          m_illegal;
  logic [1:0]  m_op, m_sel, m_sa;
  logic [31:0] m_data, m_res;
  int          m_n;
  bit          m_done, m_busy, m_err;

  always @(posedge clk) begin
    e++;
    m_valid = 1;
    if (reset) begin
      m_active = 0; m_sa = 2'b00; m_res = 32'h0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_k = e; m_op = op; m_sel = amt_sel; m_sa = amt_sel;
        m_done_edge = 32'h7fffffff; m_illegal = 0;
      end
    end else begin
      if (e == m_k + 1) begin
        if (m_op == 2'b11 || m_sel == 2'b11) begin
          m_illegal = 1; m_done_edge = e;
        end else begin
          m_data = data_in; m_n = int'(amt_in % 32); m_done_edge = e + m_n; m_res = m_data;
        end
      end else if (e <= m_done_edge) begin
        m_res = f_shift(m_data, m_op, e - m_k - 1);
      end else if (e == m_done_edge + 1) begin
        m_active = 0;
      end
    end
    m_busy = m_active;
    m_done = m_active && (e == m_done_edge);
    m_err  = m_done && m_illegal;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model ShiftAmt", 32'(ShiftAmt), 32'(m_sa));
      chk("model result", result, m_res);
      chk("model done", 32'(done), 32'(m_done));
      chk("model busy", 32'(busy), 32'(m_busy));
      chk("model err", 32'(err), 32'(m_err));
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [1:0] s, input logic [31:0] amt,
                        input logic [31:0] d, input logic [31:0] exp_res, input bit exp_err,
                        input int exp_lat, input bit poke);
    int lat;
    lat = -1;
    @(negedge clk);
    start = 1'b1; op = o; amt_sel = s; amt_in = amt; data_in = d;
    @(negedge clk);
    start = 1'b0;
    chk("dir ShiftAmt after start", 32'(ShiftAmt), 32'(s));
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      start = poke && (j == 3 || j == 10);
      if (done) begin
        lat = j;
        break;
      end
    end
    start = 1'b0;
    chk("dir latency", 32'(lat), 32'(exp_lat));
    chk("dir result", result, exp_res);
    chk("dir err", 32'(err), 32'(exp_err));
    @(negedge clk);
    chk("dir busy after done", 32'(busy), 32'h0);
    chk("dir done single pulse", 32'(done), 32'h0);
    @(negedge clk);
    chk("dir no extra done", 32'(done), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; amt_sel = 2'b00; data_in = 32'h0; amt_in = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset result", result, 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    reset = 1'b0;

    run_op(2'b00, 2'b00, 32'd4,        32'h0000000F, 32'h000000F0, 1'b0, 5,  1'b0);
    run_op(2'b10, 2'b10, 32'h00000024, 32'h80000000, 32'hF8000000, 1'b0, 5,  1'b0);
    run_op(2'b01, 2'b01, 32'd0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1,  1'b0);
    run_op(2'b01, 2'b00, 32'd31,       32'hFFFFFFFF, 32'h00000001, 1'b0, 32, 1'b1);
    run_op(2'b11, 2'b00, 32'd3,        32'h12345678, 32'h00000001, 1'b1, 1,  1'b0);
    run_op(2'b00, 2'b11, 32'd3,        32'h12345678, 32'h00000001, 1'b1, 1,  1'b0);

    // Reset in the middle of a 20-bit shift, when the remaining count is 10.
    @(negedge clk);
    start = 1'b1; op = 2'b00; amt_sel = 2'b00; amt_in = 32'd20; data_in = 32'h00000003;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid-shift result", result, 32'h00000C00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset result", result, 32'h0);
    chk("mid reset done", 32'(done), 32'h0);
    chk("mid reset busy", 32'(busy), 32'h0);
    chk("mid reset ShiftAmt", 32'(ShiftAmt), 32'h0);
    run_op(2'b00, 2'b00, 32'd1, 32'h00000001, 32'h00000002, 1'b0, 2, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset   = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 3) == 0);
      op      = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      amt_sel = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      data_in = $urandom;
      amt_in  = ($urandom & 32'hFFFFFFE0) |
                32'($urandom_range(0, 1) == 0 ? $urandom_range(0, 6) : $urandom_range(0, 31));
    end

    // Reset held for two cycles straight out of random activity.
    @(negedge clk);
    start = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rand reset ShiftAmt", 32'(ShiftAmt), 32'h0);
    chk("rand reset result", result, 32'h0);
    chk("rand reset done", 32'(done), 32'h0);
    chk("rand reset busy", 32'(busy), 32'h0);
    chk("rand reset err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
